lut_truth_table_prober: RTL and testbench
=========================================

Name: lut_truth_table_prober

Overview:
- Sequential read-back checker for the 4-input LUT test primitive (inputs A0..A3, output O, 16-bit INIT).
- The techmap flow writes a truth table into INIT. This block works in the other direction: it drives every address combination onto a LUT instance, samples O, and rebuilds the INIT word.
- It then compares the rebuilt word against an expected value and reports pass/fail.
- Used in hardware tests to confirm that mapped LUT contents survived place-and-route.

Parameters:
- WIDTH, 4, number of LUT inputs exercised (1..4); addresses 0..2^WIDTH-1 are probed.
- SETTLE, 0, extra wait cycles per address before sampling O (0..15).

Ports:
- C  input  1  clock, rising edge.
- R  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
- expected_init  input  16  expected INIT; captured on the cycle start is accepted.
- lut_a  output  4  address driven to the LUT under test (bit i -> Ai).
- lut_o  input  1  LUT O output being probed.
- busy  output  1  high from the cycle after start is accepted until the cycle before done.
- done  output  1  one-cycle pulse when the scan completes.
- pass  output  1  comparison result; valid from done until the next accepted start.
- captured_init  output  16  rebuilt truth table; bit n = O sampled at address n.

Behaviour:
- Reset (R=0, asynchronous):
  - state=IDLE; lut_a=0, busy=0, done=0, pass=0, captured_init=0.
  - Address and settle counters cleared; stored expected value cleared.
  - Reset during a scan aborts it with no done pulse.
- States: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - start=1 -> store expected_init; clear captured_init and pass.
  - Address=0, settle counter=0 -> DRIVE. busy=1 from the next cycle.
  - start=0 -> stay in IDLE.
- DRIVE:
  - lut_a = address zero-extended; bits at WIDTH and above are always 0.
  - Counter < SETTLE -> increment and stay.
  - Otherwise -> SAMPLE. With SETTLE=0, DRIVE lasts exactly 1 cycle.
- SAMPLE:
  - lut_a is held stable.
  - On the exiting clock edge, captured_init[address] <= lut_o.
  - Address == 2^WIDTH-1 -> FINISH.
  - Otherwise -> address+1, counter=0, DRIVE.
- Per-address cost: SETTLE+2 cycles. A full scan takes 2^WIDTH*(SETTLE+2) busy cycles.
- FINISH (one cycle):
  - done=1, busy=0, lut_a=0.
  - pass = (captured_init & MASK) == (stored expected & MASK), where MASK has its low 2^WIDTH bits set.
  - Next state -> IDLE.
- Bits of captured_init at and above 2^WIDTH remain 0.
- pass and captured_init hold their values in IDLE until the next accepted start.
- start while busy or in FINISH is ignored; it is not queued.
- start in the same cycle as reset deassertion is accepted on the first rising edge where R=1.
- lut_o is sampled only in SAMPLE and ignored in every other state.
- Counter and address widths: 4 bits each. Address wrap beyond 2^WIDTH-1 never occurs.

Optional Feature:
- Macro: LUT_PROBE_FAIL_ADDR_EN.
- Defined:
  - Adds output fail_addr [3:0] = lowest address n where captured bit n differs from expected bit n.
  - Adds output fail_valid [0:0], set with done when pass=0.
  - Both reset to 0, are cleared on an accepted start, and hold until the next start.
  - Computed incrementally in SAMPLE; the first mismatch is latched.
- Undefined: neither port exists and there is no mismatch-tracking logic. Pass/fail behaviour is identical in both builds.

Test Plan:
- WIDTH=4, SETTLE=0, combinational LUT model with INIT=16'h000E, expected=16'h000E, pulse start:
  - busy for 32 cycles, then done one cycle with captured_init=16'h000E, pass=1.
  - lut_a steps 0..15, each value held 2 cycles.
- Same setup with expected=16'h000F: pass=0, captured_init=16'h000E. With LUT_PROBE_FAIL_ADDR_EN: fail_addr=0, fail_valid=1.
- WIDTH=2, SETTLE=0, model INIT=4'h8 (AND), expected=16'hFFF8:
  - captured_init=16'h0008, pass=1, since upper bits are masked.
  - lut_a[3:2]=0 throughout; busy for 8 cycles.
- WIDTH=4, SETTLE=2, model whose O lags its address by 2 cycles, INIT=16'hA5C3:
  - pass=1, captured_init=16'hA5C3, done 64 cycles after busy rises.
- Mid-scan abort and restart:
  - Assert R=0 while lut_a=5 -> outputs go to 0 immediately, no done.
  - Release R, pulse start -> full scan completes with the correct result.
- Start while busy:
  - Pulse start with expected=16'h0000 at address 7 of a scan expecting 16'h000E.
  - The pulse is ignored: one done only, pass=1 against 16'h000E.

Source files
------------

// File: rtl/lut_truth_table_prober.sv
// lut_truth_table_prober: drives every address onto a 4-input LUT under test,
// samples its O output, rebuilds the INIT word and compares it (masked to the
// exercised address range) against an expected value.
// Optional build macro LUT_PROBE_FAIL_ADDR_EN adds fail_addr/fail_valid, which
// report the lowest address whose sampled bit disagrees with the expected bit.
module lut_truth_table_prober #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 0
) (
    input  logic        C,
    input  logic        R,
    input  logic        start,
    input  logic [15:0] expected_init,
    output logic [3:0]  lut_a,
    input  logic        lut_o,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured_init
`ifdef LUT_PROBE_FAIL_ADDR_EN
    ,
    output logic [3:0]  fail_addr,
    output logic        fail_valid
`endif
);

    localparam int unsigned DEPTH      = 32'd1 << WIDTH;
    localparam logic [15:0] MASK       = 16'((32'd1 << DEPTH) - 32'd1);
    localparam logic [3:0]  LAST_ADDR  = 4'(DEPTH - 32'd1);
    localparam logic [3:0]  SETTLE_MAX = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // Only the exercised low 2^WIDTH bits take part in the comparison.
    function automatic logic masked_match(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] m);
        return ((a ^ b) & m) == 16'd0;
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  addr_r, addr_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [15:0] exp_r, exp_s;
    logic [15:0] cap_r, cap_s;
    logic        pass_r, pass_s;
    logic        done_r, done_s;
    logic        busy_r, busy_s;
    logic [3:0]  lut_a_r, lut_a_s;

    // Next-state and next-output decode for the scan sequencer.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        cnt_s   = cnt_r;
        exp_s   = exp_r;
        cap_s   = cap_r;
        pass_s  = pass_r;
        done_s  = 1'b0;
        busy_s  = 1'b0;
        lut_a_s = 4'd0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    exp_s   = expected_init;
                    cap_s   = 16'd0;
                    pass_s  = 1'b0;
                    addr_s  = 4'd0;
                    cnt_s   = 4'd0;
                    busy_s  = 1'b1;
                    lut_a_s = 4'd0;
                    state_s = S_DRIVE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DRIVE: begin
                busy_s  = 1'b1;
                lut_a_s = addr_r;
                if (cnt_r != SETTLE_MAX) begin
                    cnt_s = cnt_r + 4'd1;
                end else begin
                    state_s = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                cap_s[addr_r] = lut_o;
                if (addr_r == LAST_ADDR) begin
                    pass_s  = masked_match(cap_s, exp_r, MASK);
                    done_s  = 1'b1;
                    state_s = S_FINISH;
                end else begin
                    addr_s  = addr_r + 4'd1;
                    cnt_s   = 4'd0;
                    busy_s  = 1'b1;
                    lut_a_s = addr_r + 4'd1;
                    state_s = S_DRIVE;
                end
            end
            S_FINISH: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset aborts any scan in flight.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_r <= S_IDLE;
            addr_r  <= 4'd0;
            cnt_r   <= 4'd0;
            exp_r   <= 16'd0;
            cap_r   <= 16'd0;
            pass_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            lut_a_r <= 4'd0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            cnt_r   <= cnt_s;
            exp_r   <= exp_s;
            cap_r   <= cap_s;
            pass_r  <= pass_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            lut_a_r <= lut_a_s;
        end
    end

    assign lut_a         = lut_a_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign captured_init = cap_r;

`ifdef LUT_PROBE_FAIL_ADDR_EN
    logic [3:0] fail_addr_r, fail_addr_s;
    logic       fail_valid_r, fail_valid_s;
    logic       found_r, found_s;

    // Latch the first (lowest) mismatching address as samples arrive.
    always_comb begin
        fail_addr_s  = fail_addr_r;
        fail_valid_s = fail_valid_r;
        found_s      = found_r;
        if ((state_r == S_IDLE) && start) begin
            fail_addr_s  = 4'd0;
            fail_valid_s = 1'b0;
            found_s      = 1'b0;
        end else if (state_r == S_SAMPLE) begin
            if (!found_r && (lut_o != exp_r[addr_r])) begin
                fail_addr_s = addr_r;
                found_s     = 1'b1;
            end else begin
                found_s = found_r;
            end
            if (addr_r == LAST_ADDR) begin
                fail_valid_s = !pass_s;
            end else begin
                fail_valid_s = fail_valid_r;
            end
        end else begin
            found_s = found_r;
        end
    end

    // Mismatch tracking registers.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            fail_addr_r  <= 4'd0;
            fail_valid_r <= 1'b0;
            found_r      <= 1'b0;
        end else begin
            fail_addr_r  <= fail_addr_s;
            fail_valid_r <= fail_valid_s;
            found_r      <= found_s;
        end
    end

    assign fail_addr  = fail_addr_r;
    assign fail_valid = fail_valid_r;
`else
    // Mismatch tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_lut_truth_table_prober.sv
// Scoreboard bench for lut_truth_table_prober: three instances cover
// WIDTH=4/SETTLE=0, WIDTH=2/SETTLE=0 and WIDTH=4/SETTLE=2 (lagging LUT model).
module tb_lut_truth_table_prober;

    logic C = 1'b0;
    logic R = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [15:0] exp_in = 16'd0;
    logic [3:0]  a0, a1, a2;
    logic        o0, o1, o2;
    logic        busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [15:0] cap0, cap1, cap2;
    logic [15:0] init0 = 16'h000E, init1 = 16'h0008, init2 = 16'hA5C3;
    logic [3:0]  d1 = 4'd0, d2 = 4'd0;
`ifdef LUT_PROBE_FAIL_ADDR_EN
    logic [3:0]  fa0, fa1, fa2;
    logic        fv0, fv1, fv2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] cap;
        logic        ps;
        logic [3:0]  fa;
        logic        fv;
        logic [7:0]  bc;
    } exp_t;
    exp_t sb_q[$];

    always #5 C = ~C;

    // LUT models: combinational for instances 0/1, O lagging address by 2 for 2.
    assign o0 = init0[a0];
    assign o1 = init1[a1];
    assign o2 = init2[d2];
    always @(posedge C) begin
        d1 <= a2;
        d2 <= d1;
    end

    lut_truth_table_prober #(.WIDTH(4), .SETTLE(0)) u0 (
        .C(C), .R(R), .start(start0), .expected_init(exp_in), .lut_a(a0),
        .lut_o(o0), .busy(busy0), .done(done0), .pass(pass0), .captured_init(cap0)
`ifdef LUT_PROBE_FAIL_ADDR_EN
        , .fail_addr(fa0), .fail_valid(fv0)
`endif
    );
    lut_truth_table_prober #(.WIDTH(2), .SETTLE(0)) u1 (
        .C(C), .R(R), .start(start1), .expected_init(exp_in), .lut_a(a1),
        .lut_o(o1), .busy(busy1), .done(done1), .pass(pass1), .captured_init(cap1)
`ifdef LUT_PROBE_FAIL_ADDR_EN
        , .fail_addr(fa1), .fail_valid(fv1)
`endif
    );
    lut_truth_table_prober #(.WIDTH(4), .SETTLE(2)) u2 (
        .C(C), .R(R), .start(start2), .expected_init(exp_in), .lut_a(a2),
        .lut_o(o2), .busy(busy2), .done(done2), .pass(pass2), .captured_init(cap2)
`ifdef LUT_PROBE_FAIL_ADDR_EN
        , .fail_addr(fa2), .fail_valid(fv2)
`endif
    );

    logic        done_v[3], busy_v[3], pass_v[3];
    logic [3:0]  a_v[3];
    logic [15:0] cap_v[3];
    assign done_v[0] = done0; assign done_v[1] = done1; assign done_v[2] = done2;
    assign busy_v[0] = busy0; assign busy_v[1] = busy1; assign busy_v[2] = busy2;
    assign pass_v[0] = pass0; assign pass_v[1] = pass1; assign pass_v[2] = pass2;
    assign a_v[0] = a0; assign a_v[1] = a1; assign a_v[2] = a2;
    assign cap_v[0] = cap0; assign cap_v[1] = cap1; assign cap_v[2] = cap2;
`ifdef LUT_PROBE_FAIL_ADDR_EN
    logic [3:0] fa_v[3];
    logic       fv_v[3];
    assign fa_v[0] = fa0; assign fa_v[1] = fa1; assign fa_v[2] = fa2;
    assign fv_v[0] = fv0; assign fv_v[1] = fv1; assign fv_v[2] = fv2;
`endif

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endfunction

    // Monitor: per-cycle address model while busy, scoreboard pop on done.
    int bk[3];
    int per[3];
    initial begin
        exp_t e;
        per[0] = 2; per[1] = 2; per[2] = 4;
        bk[0] = 0; bk[1] = 0; bk[2] = 0;
        forever begin
            @(negedge C);
            if (!R) begin
                for (int i = 0; i < 3; i++) bk[i] = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (busy_v[i]) begin
                        check($sformatf("lut_a%0d", i), {28'd0, a_v[i]}, bk[i] / per[i]);
                        bk[i]++;
                    end else begin
                        check($sformatf("lut_a_idle%0d", i), {28'd0, a_v[i]}, 32'd0);
                        if (done_v[i]) begin
                            if (sb_q.size() == 0) begin
                                check($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
                            end else begin
                                e = sb_q.pop_front();
                                check("sb_id", i, {24'd0, e.id});
                                check("captured_init", {16'd0, cap_v[i]}, {16'd0, e.cap});
                                check("pass", {31'd0, pass_v[i]}, {31'd0, e.ps});
                                check("busy_cycles", bk[i], {24'd0, e.bc});
`ifdef LUT_PROBE_FAIL_ADDR_EN
                                check("fail_addr", {28'd0, fa_v[i]}, {28'd0, e.fa});
                                check("fail_valid", {31'd0, fv_v[i]}, {31'd0, e.fv});
`endif
                            end
                        end
                        bk[i] = 0;
                    end
                end
            end
        end
    end

    task automatic set_start(input int id, input logic v);
        case (id)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic issue(input int id, input logic [15:0] ex, input logic [15:0] cap,
                         input logic ps, input logic [3:0] fa, input logic fv, input int bc);
        exp_t e;
        e.id = 8'(id); e.cap = cap; e.ps = ps; e.fa = fa; e.fv = fv; e.bc = 8'(bc);
        sb_q.push_back(e);
        @(posedge C); #1;
        exp_in = ex;
        set_start(id, 1'b1);
        @(posedge C); #1;
        set_start(id, 1'b0);
    endtask

    task automatic wait_done(input int id);
        for (int c = 0; c < 300; c++) begin
            @(negedge C);
            if (done_v[id]) return;
        end
        check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_addr0(input logic [3:0] v);
        for (int c = 0; c < 200; c++) begin
            @(negedge C);
            if (busy0 && a0 == v) return;
        end
        check("addr_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        // Reset state of all instances.
        repeat (3) @(posedge C);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", {31'd0, busy_v[i]}, 32'd0);
            check("rst_done", {31'd0, done_v[i]}, 32'd0);
            check("rst_pass", {31'd0, pass_v[i]}, 32'd0);
            check("rst_cap", {16'd0, cap_v[i]}, 32'd0);
            check("rst_lut_a", {28'd0, a_v[i]}, 32'd0);
        end
        R = 1'b1;

        // Matching scan, then result must hold in IDLE.
        issue(0, 16'h000E, 16'h000E, 1'b1, 4'd0, 1'b0, 32);
        wait_done(0);
        repeat (3) @(negedge C);
        check("cap_hold", {16'd0, cap0}, 32'h000E);
        check("pass_hold", {31'd0, pass0}, 32'd1);

        // Mismatch at bit 0.
        issue(0, 16'h000F, 16'h000E, 1'b0, 4'd0, 1'b1, 32);
        wait_done(0);

        // Mismatch at bit 1 only (bit 15 agrees).
        init0 = 16'h8001;
        issue(0, 16'h8003, 16'h8001, 1'b0, 4'd1, 1'b1, 32);
        wait_done(0);
        init0 = 16'h000E;

        // WIDTH=2: upper expected bits are masked off.
        issue(1, 16'hFFF8, 16'h0008, 1'b1, 4'd0, 1'b0, 8);
        wait_done(1);

        // SETTLE=2 with a lagging LUT.
        issue(2, 16'hA5C3, 16'hA5C3, 1'b1, 4'd0, 1'b0, 64);
        wait_done(2);

        // Abort mid-scan with reset: no done, outputs cleared at once.
        @(posedge C); #1;
        exp_in = 16'h000E;
        start0 = 1'b1;
        @(posedge C); #1;
        start0 = 1'b0;
        wait_addr0(4'd5);
        #2;
        R = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_done", {31'd0, done0}, 32'd0);
        check("abort_lut_a", {28'd0, a0}, 32'd0);
        check("abort_cap", {16'd0, cap0}, 32'd0);
        check("abort_pass", {31'd0, pass0}, 32'd0);

        // Start presented together with reset release.
        @(posedge C); #1;
        sb_q.push_back('{id: 8'd0, cap: 16'h000E, ps: 1'b1, fa: 4'd0, fv: 1'b0, bc: 8'd32});
        R = 1'b1;
        exp_in = 16'h000E;
        start0 = 1'b1;
        @(posedge C); #1;
        start0 = 1'b0;
        wait_done(0);

        // Start while busy is ignored.
        issue(0, 16'h000E, 16'h000E, 1'b1, 4'd0, 1'b0, 32);
        wait_addr0(4'd7);
        #1;
        exp_in = 16'h0000;
        start0 = 1'b1;
        @(posedge C); #1;
        start0 = 1'b0;
        wait_done(0);
        repeat (40) @(negedge C);
        check("no_restart_busy", {31'd0, busy0}, 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
